// File: rtl/rtlmem_rmw1x.sv
// Read-modify-write statistics engine on one port of a 1-cycle-latency RAM.
// Zeroes the RAM after reset, then serialises counter increments and CPU reads.
module rtlmem_rmw1x #(
   parameter int unsigned G_ADDR     = 10,
   parameter int unsigned G_WIDTH    = 32,
   parameter int unsigned G_INCW     = 16,
   parameter bit          G_SATURATE = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   output logic               init_done,
   input  logic               evt_vld,
   input  logic [G_ADDR-1:0]  evt_idx,
   input  logic [G_INCW-1:0]  evt_inc,
   output logic               evt_rdy,
   input  logic               cpu_req,
   input  logic [G_ADDR-1:0]  cpu_addr,
   input  logic               cpu_clr,
   output logic               cpu_ack,
   output logic [G_WIDTH-1:0] cpu_rdat,
   output logic [G_ADDR-1:0]  memad,
   output logic               memwe,
   output logic [G_WIDTH-1:0] memdi,
   output logic               memre,
   input  logic [G_WIDTH-1:0] memdo
);

   typedef enum logic [2:0] {StInit, StIdle, StRd, StWr, StCl, StAck} state_e;

   state_e               state_q, state_d;
   logic [G_ADDR-1:0]    memad_q, memad_d;
   logic                 memwe_q, memwe_d;
   logic                 memre_q, memre_d;
   logic                 cpu_ack_q, cpu_ack_d;
   logic [G_WIDTH-1:0]   cpu_rdat_q, cpu_rdat_d;
   logic                 init_done_q, init_done_d;
   logic                 last_cpu_q, last_cpu_d;
   logic                 is_cpu_q, is_cpu_d;
   logic                 clr_q, clr_d;
   logic [G_INCW-1:0]    inc_q, inc_d;

   logic                 evt_go;
   logic [G_WIDTH:0]     sum;
   logic [G_WIDTH-1:0]   sat_sum;

   assign sum     = {1'b0, memdo} + {{(G_WIDTH + 1 - G_INCW){1'b0}}, inc_q};
   assign sat_sum = (sum[G_WIDTH] && G_SATURATE) ? '1 : sum[G_WIDTH-1:0];

   // The CPU holds priority over events unless it won the previous grant.
   assign evt_rdy = (state_q == StIdle) & init_done_q & ~(cpu_req & ~last_cpu_q);
   assign evt_go  = evt_vld & evt_rdy;

   always_comb begin
      state_d     = state_q;
      memad_d     = memad_q;
      memwe_d     = memwe_q;
      memre_d     = memre_q;
      cpu_ack_d   = cpu_ack_q;
      cpu_rdat_d  = cpu_rdat_q;
      init_done_d = init_done_q;
      last_cpu_d  = last_cpu_q;
      is_cpu_d    = is_cpu_q;
      clr_d       = clr_q;
      inc_d       = inc_q;
      unique case (state_q)
         StInit: begin
            // memwe low here means the sweep has not issued its first write yet.
            if (!memwe_q) begin
               memwe_d = 1'b1;
               memad_d = '0;
            end else if (memad_q == '1) begin
               memwe_d     = 1'b0;
               init_done_d = 1'b1;
               state_d     = StIdle;
            end else begin
               memad_d = memad_q + G_ADDR'(1);
            end
         end
         StIdle: begin
            if (evt_go) begin
               state_d    = StRd;
               memre_d    = 1'b1;
               memad_d    = evt_idx;
               inc_d      = evt_inc;
               is_cpu_d   = 1'b0;
               last_cpu_d = 1'b0;
            end else if (cpu_req) begin
               state_d    = StRd;
               memre_d    = 1'b1;
               memad_d    = cpu_addr;
               clr_d      = cpu_clr;
               is_cpu_d   = 1'b1;
               last_cpu_d = 1'b1;
            end
         end
         StRd: begin
            memre_d = 1'b0;
            if (is_cpu_q) begin
               state_d = StCl;
               memwe_d = clr_q;
            end else begin
               state_d = StWr;
               memwe_d = 1'b1;
            end
         end
         StWr: begin
            memwe_d = 1'b0;
            state_d = StIdle;
         end
         StCl: begin
            memwe_d    = 1'b0;
            cpu_rdat_d = memdo;
            cpu_ack_d  = 1'b1;
            state_d    = StAck;
         end
         StAck: begin
            cpu_ack_d = 1'b0;
            state_d   = StIdle;
         end
         default: state_d = StInit;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StInit;
         memad_q     <= '0;
         memwe_q     <= 1'b0;
         memre_q     <= 1'b0;
         cpu_ack_q   <= 1'b0;
         cpu_rdat_q  <= '0;
         init_done_q <= 1'b0;
         last_cpu_q  <= 1'b0;
         is_cpu_q    <= 1'b0;
         clr_q       <= 1'b0;
         inc_q       <= '0;
      end else begin
         state_q     <= state_d;
         memad_q     <= memad_d;
         memwe_q     <= memwe_d;
         memre_q     <= memre_d;
         cpu_ack_q   <= cpu_ack_d;
         cpu_rdat_q  <= cpu_rdat_d;
         init_done_q <= init_done_d;
         last_cpu_q  <= last_cpu_d;
         is_cpu_q    <= is_cpu_d;
         clr_q       <= clr_d;
         inc_q       <= inc_d;
      end
   end

   assign init_done = init_done_q;
   assign cpu_ack   = cpu_ack_q;
   assign cpu_rdat  = cpu_rdat_q;
   assign memad     = memad_q;
   assign memwe     = memwe_q;
   assign memre     = memre_q;
   // Write data depends on memdo arriving in the write cycle itself, so it is not re-registered.
   assign memdi     = (state_q == StWr) ? sat_sum : '0;

endmodule

// File: tb/tb_rtlmem_rmw1x.sv
// Directed bench for rtlmem_rmw1x: a saturating and a wrapping instance with
// 16 x 8-bit RAM models, driven by the same stimulus.
module tb_rtlmem_rmw1x;

   logic       clk, rst;
   logic       evt_vld, cpu_req, cpu_clr;
   logic [3:0] evt_idx, cpu_addr;
   logic [7:0] evt_inc;

   logic       s_init_done, s_evt_rdy, s_cpu_ack, s_memwe, s_memre;
   logic [7:0] s_cpu_rdat, s_memdi, s_memdo;
   logic [3:0] s_memad;
   logic       w_init_done, w_evt_rdy, w_cpu_ack, w_memwe, w_memre;
   logic [7:0] w_cpu_rdat, w_memdi, w_memdo;
   logic [3:0] w_memad;

   logic [7:0] ram_s [16];
   logic [7:0] ram_w [16];

   int errors = 0;
   int checks = 0;
   int overlap = 0;

   rtlmem_rmw1x #(.G_ADDR(4), .G_WIDTH(8), .G_INCW(8), .G_SATURATE(1'b1)) u_sat (
      .clk(clk), .rst(rst), .init_done(s_init_done),
      .evt_vld(evt_vld), .evt_idx(evt_idx), .evt_inc(evt_inc), .evt_rdy(s_evt_rdy),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_clr(cpu_clr),
      .cpu_ack(s_cpu_ack), .cpu_rdat(s_cpu_rdat),
      .memad(s_memad), .memwe(s_memwe), .memdi(s_memdi), .memre(s_memre), .memdo(s_memdo)
   );

   rtlmem_rmw1x #(.G_ADDR(4), .G_WIDTH(8), .G_INCW(8), .G_SATURATE(1'b0)) u_wrap (
      .clk(clk), .rst(rst), .init_done(w_init_done),
      .evt_vld(evt_vld), .evt_idx(evt_idx), .evt_inc(evt_inc), .evt_rdy(w_evt_rdy),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_clr(cpu_clr),
      .cpu_ack(w_cpu_ack), .cpu_rdat(w_cpu_rdat),
      .memad(w_memad), .memwe(w_memwe), .memdi(w_memdi), .memre(w_memre), .memdo(w_memdo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (s_memwe) ram_s[s_memad] <= s_memdi;
      if (s_memre) s_memdo <= ram_s[s_memad];
      if (w_memwe) ram_w[w_memad] <= w_memdi;
      if (w_memre) w_memdo <= ram_w[w_memad];
   end

   always @(negedge clk) begin
      if ((s_memre && s_memwe) || (w_memre && w_memwe)) overlap <= overlap + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_evt(input logic [3:0] idx, input logic [7:0] inc,
                         input logic [7:0] exp_s, input logic [7:0] exp_w);
      evt_vld = 1'b1; evt_idx = idx; evt_inc = inc;
      #1;
      chk("evt_rdy", {s_evt_rdy, w_evt_rdy}, 2'b11);
      step();
      evt_vld = 1'b0; evt_idx = ~idx; evt_inc = 8'hff;
      chk("evt_rd", {s_memre, s_memwe, s_memad, w_memre, w_memwe, w_memad},
          {1'b1, 1'b0, idx, 1'b1, 1'b0, idx});
      step();
      chk("evt_wr_s", {s_memwe, s_memre, s_memad, s_memdi}, {1'b1, 1'b0, idx, exp_s});
      chk("evt_wr_w", {w_memwe, w_memre, w_memad, w_memdi}, {1'b1, 1'b0, idx, exp_w});
      step();
      chk("evt_done", {s_evt_rdy, s_memwe, w_evt_rdy, w_memwe}, 4'b1010);
   endtask

   task automatic do_cpu(input logic [3:0] addr, input logic clr,
                         input logic [7:0] exp_s, input logic [7:0] exp_w);
      cpu_req = 1'b1; cpu_addr = addr; cpu_clr = clr;
      #1;
      step();
      cpu_addr = ~addr; cpu_clr = ~clr;
      chk("cpu_rd", {s_memre, s_memwe, s_memad, s_cpu_ack}, {1'b1, 1'b0, addr, 1'b0});
      step();
      chk("cpu_cl", {s_memre, s_memwe, s_memdi, w_memwe, w_memdi}, {1'b0, clr, 8'h00, clr, 8'h00});
      step();
      chk("cpu_ack_s", {s_cpu_ack, s_cpu_rdat}, {1'b1, exp_s});
      chk("cpu_ack_w", {w_cpu_ack, w_cpu_rdat}, {1'b1, exp_w});
      cpu_req = 1'b0; cpu_addr = 4'h0; cpu_clr = 1'b0;
      step();
      chk("cpu_idle", {s_cpu_ack, s_cpu_rdat, s_evt_rdy}, {1'b0, exp_s, 1'b1});
   endtask

   initial begin
      string log;
      int    nack;
      int    n;
      rst = 1'b1;
      evt_vld = 1'b0; evt_idx = 4'h0; evt_inc = 8'h00;
      cpu_req = 1'b0; cpu_addr = 4'h0; cpu_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_s", {s_init_done, s_evt_rdy, s_memwe, s_memre, s_memad, s_memdi, s_cpu_ack,
                      s_cpu_rdat}, 0);
      chk("reset_w", {w_init_done, w_evt_rdy, w_memwe, w_memre, w_memad, w_memdi, w_cpu_ack,
                      w_cpu_rdat}, 0);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step();
         chk("init_sweep", {s_memwe, s_memre, s_memad, s_memdi, s_init_done, w_memwe, w_memad},
             {1'b1, 1'b0, 4'(i), 8'h00, 1'b0, 1'b1, 4'(i)});
      end
      step();
      chk("init_done", {s_init_done, s_evt_rdy, s_memwe, w_init_done, w_evt_rdy}, 5'b11011);

      do_evt(4'd3, 8'd5, 8'd5, 8'd5);
      do_evt(4'd3, 8'd5, 8'd10, 8'd10);
      do_cpu(4'd3, 1'b0, 8'd10, 8'd10);

      do_evt(4'd7, 8'd200, 8'd200, 8'd200);
      do_evt(4'd7, 8'd100, 8'd255, 8'd44);
      do_cpu(4'd7, 1'b0, 8'd255, 8'd44);

      do_cpu(4'd3, 1'b1, 8'd10, 8'd10);
      do_cpu(4'd3, 1'b0, 8'd0, 8'd0);

      do_evt(4'd5, 8'd9, 8'd9, 8'd9);
      do_evt(4'd5, 8'd0, 8'd9, 8'd9);

      // Both sides requesting continuously from idle with the event side last served.
      evt_vld = 1'b1; evt_idx = 4'd9; evt_inc = 8'd1;
      cpu_req = 1'b1; cpu_addr = 4'd9; cpu_clr = 1'b0;
      #1;
      chk("arb_first", {s_evt_rdy, w_evt_rdy}, 2'b00);
      log = "";
      nack = 0;
      for (int c = 1; c <= 20; c++) begin
         step();
         if (s_memwe) log = {log, "E"};
         if (s_cpu_ack) begin
            log = {log, "C"};
            chk("arb_rdat", {s_cpu_rdat, w_cpu_rdat}, {8'(nack), 8'(nack)});
            nack++;
         end
      end
      evt_vld = 1'b0; cpu_req = 1'b0;
      checks++;
      assert (log == "CECECE") else begin
         errors++;
         $error("FAIL arb_order: observed=%s expected=CECECE", log);
      end
      step();
      do_cpu(4'd9, 1'b0, 8'd3, 8'd3);

      // Abort an increment with reset during its write cycle.
      do_evt(4'd11, 8'd6, 8'd6, 8'd6);
      evt_vld = 1'b1; evt_idx = 4'd11; evt_inc = 8'd6;
      #1;
      step();
      evt_vld = 1'b0;
      step();
      chk("abort_wr", {s_memwe, s_memdi}, {1'b1, 8'd12});
      rst = 1'b1;
      #1;
      chk("abort_rst", {s_memwe, s_memre, s_init_done, s_evt_rdy, w_memwe, w_init_done}, 0);
      step();
      step();
      rst = 1'b0;
      n = 0;
      while (!s_init_done && n < 40) begin
         step();
         n++;
      end
      chk("reinit", {s_init_done, w_init_done}, 2'b11);
      chk("reinit_len", n, 17);
      do_cpu(4'd11, 1'b0, 8'd0, 8'd0);
      do_cpu(4'd7, 1'b0, 8'd0, 8'd0);

      chk("re_we_excl", overlap, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
